// File: rtl/ooo_loader_pkg.sv
// ooo_loader_pkg: shared loader FSM states, NOP fill instruction and word type
package ooo_loader_pkg;
  typedef enum logic [1:0] {LDR_CLEAR, LDR_LOAD, LDR_RELEASE, LDR_RUN} ldr_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/imem_stream_loader_packer.sv
// imem_byte_packer: gathers LSB-first stream bytes into 32-bit words and flags a word cut short by the last byte
module imem_byte_packer
  import ooo_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       last,
  output word_t      word,
  output logic       done,
  output logic       partial
);
  logic [1:0]  r_idx;
  logic [23:0] r_lanes;
  assign word = {data, r_lanes};
  assign done = en && r_idx == 2'd3;
  assign partial = en && last && r_idx != 2'd3;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_lanes <= '0;
    end else if (en) begin
      r_idx <= last ? 2'd0 : r_idx + 2'd1;
      r_lanes <= {data, r_lanes[23:8]};
    end
  end
endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: NOP-fills the instruction BRAM, packs a byte stream into it, then releases core reset (IMEM_LOADER_CHECKSUM_EN adds a word checksum)
module imem_stream_loader
  import ooo_loader_pkg::*;
#(
  parameter int    ADDR_W   = 9,
  parameter word_t NOP_WORD = NOP_INSTR,
  parameter int    RST_HOLD = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output word_t             mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              partial,
  output word_t             checksum
);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  ldr_state_t        r_state, w_next;
  logic [ADDR_W-1:0] r_fill;
  logic [HOLD_W-1:0] r_hold;
  logic              r_fin, w_acc, w_full, w_done, w_part;
  word_t             w_word;
  assign byte_ready = r_state == LDR_LOAD && !r_fin;
  assign core_rst = r_state != LDR_RUN;
  assign load_done = r_state == LDR_RUN;
  assign w_acc = byte_valid && byte_ready;
  assign w_full = word_count[ADDR_W];
  imem_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .en      (w_acc && !w_full),
    .data    (byte_data),
    .last    (byte_last),
    .word    (w_word),
    .done    (w_done),
    .partial (w_part)
  );
  always_comb begin
    w_next = r_state;
    w_next = (r_state == LDR_CLEAR && r_fill == '1) ? LDR_LOAD :
             (r_state == LDR_LOAD && r_fin) ? LDR_RELEASE :
             (r_state == LDR_RELEASE && r_hold == HOLD_W'(RST_HOLD - 1)) ? LDR_RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= LDR_CLEAR;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      word_count <= '0;
      overflow <= 1'b0;
      partial <= 1'b0;
      r_fill <= '0;
      r_fin <= 1'b0;
      r_hold <= '0;
    end else begin
      mem_we <= r_state == LDR_CLEAR || w_done;
      if (r_state == LDR_CLEAR) begin
        mem_addr <= r_fill;
        mem_wdata <= NOP_WORD;
        r_fill <= r_fill + 1'b1;
      end
      if (w_done) begin
        mem_addr <= word_count[ADDR_W-1:0];
        mem_wdata <= w_word;
        word_count <= word_count + 1'b1;
      end
      overflow <= overflow || (w_acc && w_full);
      partial <= partial || w_part;
      r_fin <= r_fin || (w_acc && byte_last);
      r_hold <= r_state == LDR_RELEASE ? r_hold + 1'b1 : '0;
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) checksum <= rst ? '0 : w_done ? checksum + w_word : checksum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: randomized scoreboard bench for the instruction-memory stream loader
module tb_imem_stream_loader;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;
  localparam int HOLD = 10;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, rst = 1'b1, byte_valid = 1'b0, byte_last = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_ready, mem_we, core_rst, load_done, overflow, partial;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, checksum;
  logic [AW:0] word_count;
  wr_t exp_q[$];
  logic [31:0] sh_mem [DEPTH];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_sum;
  int m_words;
  bit m_ovf, m_part;
  int n_chk = 0, n_pass = 0, stalls = 0;
  always #5 clk = ~clk;
  imem_stream_loader #(.ADDR_W(AW), .NOP_WORD(NOP), .RST_HOLD(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .word_count (word_count),
    .overflow   (overflow),
    .partial    (partial),
    .checksum   (checksum)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) begin : monitor
    wr_t w;
    if (mem_we) begin
      sh_mem[mem_addr] = mem_wdata;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        w = exp_q.pop_front();
        if (mem_addr === w.a && mem_wdata === w.d) n_pass++;
        else $display("FAIL mem_write: got addr %0d data %h expected addr %0d data %h", mem_addr, mem_wdata, w.a, w.d);
      end
    end
  end
  task automatic do_reset();
    int cyc = 0;
    int we = 0;
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({AW'(a), NOP});
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_load_done", load_done, 0);
    check("rst_word_count", word_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_partial", partial, 0);
    check("rst_checksum", checksum, 0);
    rst = 1'b0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (mem_we) we++;
      if (byte_ready) break;
    end
    check("ready_rise_cycle", cyc, DEPTH + 1);
    check("fill_we_cycles", we, DEPTH);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    byte_valid = 1'b1;
    byte_data = d;
    byte_last = l;
    while (!byte_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("ready_timeout", byte_ready, 1);
    stalls += t;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_last = 1'b0;
  endtask
  task automatic stream(input logic [7:0] bq[$], input bit with_last, input bit gaps);
    logic [31:0] w = '0;
    int n = bq.size();
    for (int a = 0; a < DEPTH; a++) m_mem[a] = NOP;
    m_words = 0;
    m_sum = '0;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      w = {bq[k], w[31:8]};
      if (k % 4 == 3 && k / 4 < DEPTH) begin
        exp_q.push_back({AW'(k / 4), w});
        m_mem[k / 4] = w;
        m_words++;
        m_sum += w;
      end
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_byte(bq[k], with_last && k == n - 1);
    end
    m_ovf = n > 4 * DEPTH;
    m_part = with_last && n <= 4 * DEPTH && n % 4 != 0;
  endtask
  task automatic finish_check();
    int h = 0;
    int bad = 0;
    check("ready_after_last", byte_ready, 0);
    @(negedge clk);
    while (h < 100) begin
      @(negedge clk);
      if (!core_rst) break;
      h++;
    end
    check("core_rst_hold", h, HOLD);
    check("load_done", load_done, 1);
    check("word_count", word_count, m_words);
    check("overflow", overflow, m_ovf);
    check("partial", partial, m_part);
    check("checksum", checksum, CSUM ? m_sum : 32'h0);
    check("pending_writes", exp_q.size(), 0);
    check("stall_cycles", stalls, 0);
    for (int a = 0; a < DEPTH; a++) if (sh_mem[a] !== m_mem[a]) bad++;
    check("mem_image_mismatches", bad, 0);
    byte_valid = 1'b1;
    byte_last = 1'b1;
    byte_data = 8'($urandom);
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    byte_last = 1'b0;
    check("run_ready", byte_ready, 0);
    check("run_word_count", word_count, m_words);
    check("run_core_rst", core_rst, 0);
  endtask
  task automatic rand_bytes(output logic [7:0] q[$], input int n);
    q.delete();
    repeat (n) q.push_back(8'($urandom));
  endtask
  initial begin
    logic [7:0] q[$];
    do_reset();
    q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    stream(q, 1'b1, 1'b0);
    finish_check();
    do_reset();
    rand_bytes(q, 6);
    stream(q, 1'b1, 1'b1);
    finish_check();
    do_reset();
    rand_bytes(q, 1);
    stream(q, 1'b1, 1'b0);
    finish_check();
    repeat (3) begin
      do_reset();
      rand_bytes(q, $urandom_range(1, 120));
      stream(q, 1'b1, 1'b1);
      finish_check();
    end
    do_reset();
    rand_bytes(q, 14);
    stream(q, 1'b0, 1'b0);
    check("count_before_abort", word_count, 3);
    do_reset();
    q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    stream(q, 1'b1, 1'b1);
    finish_check();
    do_reset();
    rand_bytes(q, 4 * DEPTH + 5);
    stream(q, 1'b1, 1'b0);
    finish_check();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end
endmodule
